// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction fetch stage that sits directly after the program counter.
// It samples the current PC, fetches one instruction from instruction memory
// over a req/ack handshake, and holds that instruction in an output register
// until decode takes it. A one-cycle pc_advance pulse is raised for every
// fetch that reaches the output register. The control logic turns that pulse
// into the PC increment. A flush (branch/jump redirect) throws away whatever
// fetch is in flight or held.
//
// Handshakes:
//   imem_req/imem_ack : once imem_req is raised it stays high, and imem_addr
//                       stays constant, until the first cycle imem_ack=1.
//                       imem_ack is ignored while imem_req=0. A request is
//                       never withdrawn early. A flushed request is therefore
//                       finished in DROP and its data is discarded.
//   if_valid/id_ready : a transfer to decode happens on a rising clk edge
//                       where if_valid=1 and id_ready=1. if_instr and if_pc
//                       hold steady while if_valid=1.
//   flush             : takes priority over imem_ack and id_ready in every
//                       state.
//
// Ports:
//   clk         system clock; all state changes on the rising edge
//   reset       synchronous active-high reset
//   pc_in       current PC value
//   flush       redirect (branch/jump) taken this cycle
//   pc_advance  one-cycle pulse that requests a PC increment
//   imem_req    instruction-memory request
//   imem_addr   instruction-memory request address
//   imem_ack    memory returns data this cycle
//   imem_rdata  instruction data, valid together with imem_ack
//   if_valid    output register holds a valid instruction
//   if_instr    fetched instruction
//   if_pc       address of if_instr
//   id_ready    decode accepts the instruction this cycle
//   dbg_state   current FSM state (0=IDLE 1=REQ 2=FULL 3=DROP)
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter int ADDR_WIDTH  = 16,
    parameter int INSTR_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [ADDR_WIDTH-1:0]  pc_in,
    input  logic                   flush,
    output logic                   pc_advance,
    output logic                   imem_req,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    input  logic                   imem_ack,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic                   if_valid,
    output logic [INSTR_WIDTH-1:0] if_instr,
    output logic [ADDR_WIDTH-1:0]  if_pc,
    input  logic                   id_ready,
    output logic [1:0]             dbg_state
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FULL = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t                 state_q;
    state_t                 state_d;
    logic                   req_d;
    logic [ADDR_WIDTH-1:0]  addr_d;
    logic                   adv_d;
    logic                   valid_d;
    logic [INSTR_WIDTH-1:0] instr_d;
    logic [ADDR_WIDTH-1:0]  ifpc_d;

    // Next-state and next-output logic. Every output is registered, so this
    // block computes the value each output register takes on the next edge.
    always_comb begin
        state_d = state_q;
        req_d   = imem_req;
        addr_d  = imem_addr;
        adv_d   = 1'b0;          // pc_advance is a pulse unless set below
        valid_d = if_valid;
        instr_d = if_instr;
        ifpc_d  = if_pc;

        case (state_q)
            IDLE: begin
                req_d = 1'b0;
                // During a redirect the PC is not settled yet. It is sampled
                // on the first cycle without a flush.
                if (!flush) begin
                    addr_d  = pc_in;
                    req_d   = 1'b1;
                    state_d = REQ;
                end
            end

            REQ: begin
                if (imem_ack) begin
                    req_d = 1'b0;
                    if (flush) begin
                        state_d = IDLE;
                    end else begin
                        instr_d = imem_rdata;
                        ifpc_d  = imem_addr;
                        valid_d = 1'b1;
                        adv_d   = 1'b1;
                        state_d = FULL;
                    end
                end else if (flush) begin
                    // The request cannot be withdrawn, so keep it up and
                    // throw its data away when it arrives.
                    state_d = DROP;
                end
            end

            DROP: begin
                if (imem_ack) begin
                    req_d   = 1'b0;
                    state_d = IDLE;
                end
            end

            FULL: begin
                // The PC increment from pc_advance lands while this state is
                // held, so the next IDLE samples the new PC.
                if (flush || id_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end

            default: begin
                req_d   = 1'b0;
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            imem_req   <= 1'b0;
            imem_addr  <= '0;
            pc_advance <= 1'b0;
            if_valid   <= 1'b0;
            if_instr   <= '0;
            if_pc      <= '0;
        end else begin
            state_q    <= state_d;
            imem_req   <= req_d;
            imem_addr  <= addr_d;
            pc_advance <= adv_d;
            if_valid   <= valid_d;
            if_instr   <= instr_d;
            if_pc      <= ifpc_d;
        end
    end

    assign dbg_state = state_q;

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//
// Bench for fetch_stage. The main process plays three roles: the PC/control
// logic, the instruction memory and the decode stage. Each time it issues a
// memory ack that must end in an instruction reaching decode, it pushes the
// expected (pc, instruction) pair onto exp_q. The expected pair comes from
// the bench's own architectural PC and memory contents. A separate negedge
// monitor pops an entry whenever a new instruction appears on if_valid. It
// also checks the handshake rules and the flush rules.
// ---------------------------------------------------------------------------
module tb_fetch_stage;
  localparam int AW = 16;
  localparam int IW = 16;
  localparam logic [1:0] IDLE_CODE = 2'd0;

  // clock/reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset;
  logic [AW-1:0] pc_in;
  logic          flush;
  logic          pc_advance;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [IW-1:0] imem_rdata;
  logic          if_valid;
  logic [IW-1:0] if_instr;
  logic [AW-1:0] if_pc;
  logic          id_ready;
  logic [1:0]    dbg_state;

  fetch_stage #(.ADDR_WIDTH(AW), .INSTR_WIDTH(IW)) dut (
    .clk(clk),
    .reset(reset),
    .pc_in(pc_in),
    .flush(flush),
    .pc_advance(pc_advance),
    .imem_req(imem_req),
    .imem_addr(imem_addr),
    .imem_ack(imem_ack),
    .imem_rdata(imem_rdata),
    .if_valid(if_valid),
    .if_instr(if_instr),
    .if_pc(if_pc),
    .id_ready(id_ready),
    .dbg_state(dbg_state)
  );

  // scoreboard and counters
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  int got_cnt = 0;
  int adv_cnt = 0;
  int deliv_cnt = 0;
  int adv_base = 0;
  int deliv_base = 0;
  bit mon_en = 1'b0;

  // stimulus knobs
  int lat_min, lat_max, rdy_min, rdy_max;
  int flush_mode;   // 0 none, 1 one cycle before ack, 2 with ack, 3 with id_ready, 4 random
  int flush_pct, flush_left;
  bit redir_rand;
  logic [AW-1:0] redir_fixed;

  // environment model state
  int req_age, lat_cur, full_age, rdy_cur;
  bit dropped, adv_last;
  logic [AW-1:0] redir_next;

  // instruction memory contents
  function automatic logic [IW-1:0] mem_word(input logic [AW-1:0] a);
    return a * 16'h9E37 + 16'h1234;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // driver tasks
  // One cycle of environment behaviour. It is called just after a rising
  // edge and chooses the inputs for the next edge.
  task automatic drive_cycle();
    logic ack_n, rdy_n, flush_n, deliver;
    // PC/control: a redirect wins over the increment request.
    if (flush) pc_in = redir_next;
    else if (adv_last) pc_in = pc_in + 1'b1;
    adv_last = pc_advance;

    // memory
    ack_n = 1'b0;
    if (imem_req) begin
      if (req_age == 0) lat_cur = $urandom_range(lat_max, lat_min);
      ack_n = (req_age >= lat_cur);
    end

    // decode
    rdy_n = 1'($urandom_range(1, 0));
    if (if_valid) begin
      if (full_age == 0) rdy_cur = $urandom_range(rdy_max, rdy_min);
      rdy_n = (full_age >= rdy_cur);
    end

    // redirects
    flush_n = 1'b0;
    case (flush_mode)
      1: flush_n = (flush_left > 0) && imem_req && (lat_cur >= 1) && (req_age == lat_cur - 1);
      2: flush_n = (flush_left > 0) && ack_n;
      3: flush_n = (flush_left > 0) && if_valid && rdy_n;
      4: flush_n = ($urandom_range(99, 0) < flush_pct);
      default: flush_n = 1'b0;
    endcase
    if (flush_n && flush_mode != 4) flush_left--;
    if (redir_rand) redir_next = ($urandom_range(3, 0) == 0) ? 16'hFFFF : 16'($urandom);
    else redir_next = redir_fixed;

    // Architecturally, a fetch that finishes with no redirect since it was
    // issued delivers the instruction at the current PC.
    if (imem_req && ack_n) begin
      deliver = !flush_n && !dropped;
      if (deliver) begin
        exp_q.push_back({pc_in, mem_word(pc_in)});
        deliv_cnt++;
        imem_rdata = mem_word(imem_addr);
      end else begin
        imem_rdata = 16'hDEAD;
      end
      dropped = 1'b0;
    end else begin
      if (imem_req && flush_n) dropped = 1'b1;
      imem_rdata = 16'($urandom);
    end

    req_age = imem_req ? req_age + 1 : 0;
    full_age = if_valid ? full_age + 1 : 0;
    flush = flush_n;
    imem_ack = ack_n;
    id_ready = rdy_n;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_pc_advance"}, pc_advance, 0);
    chk({tag, "_imem_req"}, imem_req, 0);
    chk({tag, "_imem_addr"}, imem_addr, 0);
    chk({tag, "_if_valid"}, if_valid, 0);
    chk({tag, "_if_instr"}, if_instr, 0);
    chk({tag, "_if_pc"}, if_pc, 0);
    chk({tag, "_state"}, dbg_state, IDLE_CODE);
  endtask

  task automatic do_reset(input logic [AW-1:0] start_pc);
    mon_en = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1; flush = 1'b0; imem_ack = 1'b0; id_ready = 1'b0;
    imem_rdata = '0; pc_in = start_pc;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    reset = 1'b0;
    req_age = 0; full_age = 0; lat_cur = 0; rdy_cur = 0;
    dropped = 1'b0; adv_last = 1'b0;
    adv_base = adv_cnt; deliv_base = deliv_cnt;
    mon_en = 1'b1;
  endtask

  task automatic run_until(input int n, input int max_cycles, input string name);
    int target;
    target = got_cnt + n;
    for (int c = 0; c < max_cycles && got_cnt < target; c++) begin
      @(posedge clk); #1;
      drive_cycle();
    end
    checks++;
    if (got_cnt < target) begin
      errors++;
      $display("FAIL %s_timeout actual=%0d required=%0d", name, got_cnt, target);
    end
  endtask

  task automatic end_phase(input string name);
    @(posedge clk); #1;
    imem_ack = 1'b0; flush = 1'b0; id_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk({name, "_queue_empty"}, exp_q.size(), 0);
    chk({name, "_advance_count"}, adv_cnt - adv_base, deliv_cnt - deliv_base);
  endtask

  // monitor
  logic          p_valid, p_req, p_ack, p_flush;
  logic [IW-1:0] p_instr;
  logic [AW-1:0] p_pc, p_addr;

  always @(negedge clk) begin
    logic [31:0] e;
    if (!mon_en) begin
      p_valid = 1'b0; p_req = 1'b0; p_ack = 1'b0; p_flush = 1'b0;
      p_instr = '0; p_pc = '0; p_addr = '0;
      exp_q.delete();
    end else begin
      // a new instruction and its increment request appear together
      chk("pc_advance_pulse", pc_advance, if_valid && !p_valid);
      if (pc_advance) adv_cnt++;
      if (if_valid && !p_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_instr actual=pc 0x%0h instr 0x%0h required=none", if_pc, if_instr);
        end else begin
          e = exp_q.pop_front();
          chk("if_pc", if_pc, e[31:16]);
          chk("if_instr", if_instr, e[15:0]);
          got_cnt++;
        end
      end else if (if_valid) begin
        chk("hold_instr", if_instr, p_instr);
        chk("hold_pc", if_pc, p_pc);
      end
      if (p_req && !p_ack) begin
        chk("req_held", imem_req, 1);
        chk("addr_stable", imem_addr, p_addr);
      end
      chk("req_while_full", imem_req && if_valid, 0);
      if (p_flush) begin
        chk("flush_valid", if_valid, 0);
        if (p_valid || (p_req && p_ack)) chk("flush_state", dbg_state, IDLE_CODE);
      end
      p_valid = if_valid; p_instr = if_instr; p_pc = if_pc;
      p_req = imem_req; p_addr = imem_addr; p_ack = imem_ack; p_flush = flush;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; flush = 1'b0; imem_ack = 1'b0; id_ready = 1'b0;
    imem_rdata = '0; pc_in = '0;
    lat_min = 0; lat_max = 0; rdy_min = 0; rdy_max = 0;
    flush_mode = 0; flush_pct = 0; flush_left = 0;
    redir_rand = 1'b0; redir_fixed = 16'h0040; redir_next = 16'h0040;

    // basic single-cycle fetches starting at 0x0000
    do_reset(16'h0000);
    run_until(3, 100, "basic");
    end_phase("basic");

    // slow memory: request held for four cycles
    do_reset(16'h0010);
    lat_min = 3; lat_max = 3;
    run_until(2, 100, "slow_mem");
    end_phase("slow_mem");

    // decode stalls for five cycles
    do_reset(16'h0020);
    lat_min = 0; lat_max = 0; rdy_min = 5; rdy_max = 5;
    run_until(2, 100, "stall");
    end_phase("stall");

    // flush one cycle before ack, redirect to 0x0040
    do_reset(16'h0030);
    lat_min = 1; lat_max = 1; rdy_min = 0; rdy_max = 0;
    flush_mode = 1; flush_left = 1;
    run_until(2, 100, "flush_req");
    end_phase("flush_req");

    // flush together with ack
    do_reset(16'h0030);
    lat_min = 0; lat_max = 0; flush_mode = 2; flush_left = 1;
    run_until(2, 100, "flush_ack");
    end_phase("flush_ack");

    // flush together with id_ready in FULL
    do_reset(16'h0030);
    rdy_min = 1; rdy_max = 1; flush_mode = 3; flush_left = 1;
    run_until(3, 100, "flush_full");
    end_phase("flush_full");

    // reset during an outstanding request, then a late ack
    do_reset(16'h0050);
    flush_mode = 0; lat_min = 5; lat_max = 5;
    mon_en = 1'b0;
    begin
      bit seen;
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
        @(posedge clk); #1;
        if (imem_req) seen = 1'b1;
        else drive_cycle();
      end
      chk("reset_in_req_reached", seen, 1);
    end
    reset = 1'b1; imem_ack = 1'b0; flush = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0; imem_ack = 1'b1; imem_rdata = 16'hBEEF;
    @(negedge clk);
    check_reset_outputs("mid_req_reset");
    @(posedge clk); #1;
    imem_ack = 1'b0;
    @(negedge clk);
    chk("late_ack_valid", if_valid, 0);
    chk("late_ack_advance", pc_advance, 0);
    chk("late_ack_new_req", imem_req, 1);
    chk("late_ack_addr", imem_addr, 16'h0050);
    @(negedge clk);
    chk("late_ack_valid2", if_valid, 0);

    // randomized traffic with redirects, including wrap from 0xFFFF
    do_reset(16'($urandom));
    lat_min = 0; lat_max = 4; rdy_min = 0; rdy_max = 3;
    flush_mode = 4; flush_pct = 12; redir_rand = 1'b1;
    run_until(80, 4000, "random");
    end_phase("random");

    // final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction fetch stage directly downstream of the program counter.
- Takes the current PC, issues a request to instruction memory over a req/ack handshake, and holds the returned instruction in an output register for decode (valid/ready).
- Pulses pc_advance after each accepted fetch; the control logic maps this pulse to the PC "increment" command.
- flush discards in-flight or held fetches when a branch or jump redirects the PC.

Parameters:
- ADDR_WIDTH, 16, width of PC and instruction-memory address
- INSTR_WIDTH, 16, width of instruction word

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- pc_in  input  ADDR_WIDTH  current PC value
- flush  input  1  redirect (branch/jump) taken this cycle
- pc_advance  output  1  one-cycle pulse: request PC increment
- imem_req  output  1  instruction-memory request
- imem_addr  output  ADDR_WIDTH  request address
- imem_ack  input  1  memory returns data this cycle; ignored while imem_req=0
- imem_rdata  input  INSTR_WIDTH  instruction data, valid with imem_ack
- if_valid  output  1  instruction register holds a valid instruction
- if_instr  output  INSTR_WIDTH  fetched instruction
- if_pc  output  ADDR_WIDTH  address of if_instr
- id_ready  input  1  decode accepts instruction this cycle

Behaviour:
- Reset (synchronous, active-high, on clk rising edge): state=IDLE; imem_req=0, imem_addr=0, pc_advance=0, if_valid=0, if_instr=0, if_pc=0. Reset overrides all other inputs, including mid-request; an outstanding memory ack after reset is ignored.
- All outputs are registered.
- States: IDLE, REQ, FULL, DROP.
- IDLE, flush=0: capture imem_addr<=pc_in, set imem_req<=1, go to REQ.
- IDLE, flush=1: stay in IDLE. The PC is being redirected; it is sampled next cycle.
- REQ:
  - imem_req stays 1; imem_addr stays stable until ack.
  - ack=1, flush=0: if_instr<=imem_rdata, if_pc<=imem_addr, if_valid<=1, pc_advance<=1 for exactly one cycle, imem_req<=0, go to FULL.
  - ack=1, flush=1: discard data; imem_req<=0; no pc_advance; if_valid stays 0; go to IDLE.
  - ack=0, flush=1: go to DROP; imem_req remains 1, because the memory protocol forbids withdrawing a request before ack.
  - ack=0, flush=0: wait indefinitely.
- DROP:
  - Hold the request until imem_ack; discard the data; imem_req<=0; go to IDLE.
  - flush during DROP has no further effect.
- FULL:
  - if_valid=1; if_instr and if_pc are stable.
  - flush=1 (priority over id_ready): if_valid<=0, go to IDLE.
  - id_ready=1: transfer completes on this edge; if_valid<=0, go to IDLE.
  - Otherwise: hold.
- Flush has priority over ack and id_ready in every state.
- Latency:
  - imem_req is visible 1 cycle after entering IDLE with flush=0.
  - if_valid and pc_advance rise on the edge where ack is sampled.
  - Minimum fetch period is 3 cycles (IDLE -> REQ -> FULL, with single-cycle ack and immediate id_ready).
  - Re-entering IDLE after FULL guarantees that pc_in reflects the pc_advance increment before it is sampled again.
- pc_advance is never asserted for a discarded fetch. There is at most one pc_advance per transfer to FULL.
- Address wrap is handled by the PC; this block samples pc_in as-is (0xFFFF is a legal address).
- if_instr and if_pc keep their last values when if_valid=0.

Test Plan:
- Reset, then release with pc_in=0x0000; memory acks 1 cycle after req with rdata=0x1234; id_ready=1 -> imem_addr=0x0000; if_valid=1, if_instr=0x1234, if_pc=0x0000; single pc_advance pulse; next request at pc_in=0x0001.
- Memory ack delayed 4 cycles at pc_in=0x0010 -> imem_req held high and imem_addr=0x0010 stable for all 4 cycles; exactly one pc_advance pulse.
- FULL with id_ready=0 for 5 cycles -> if_valid=1 and if_instr unchanged throughout; no new imem_req until id_ready=1.
- flush asserted in REQ 1 cycle before ack (rdata=0xDEAD) -> DROP; 0xDEAD never appears with if_valid=1; no pc_advance; next fetch uses the redirected pc_in=0x0040.
- flush coincident with ack, and separately flush coincident with id_ready in FULL -> both cases discarded; if_valid=0 next cycle; state IDLE.
- reset asserted while in REQ -> all outputs 0 next cycle; a late imem_ack=1 arriving after reset produces no if_valid.
